ins_prefetch: RTL and testbench

INS_PREFETCH -- requirements
Module: ins_prefetch

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/ins_prefetch_if.sv | 41 ++++
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/ins_prefetch.sv | 97 +++++++++
 tb/tb_ins_prefetch.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fetch_pkg
// Purpose  : Shared widths, reset default and buffer entry type for fetch.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Sequential fetch address; wraps at 2^XLEN.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ins_prefetch_if.sv
`default_nettype none
// ============================================================================
// Interface : ins_prefetch_if
// Purpose   : IMEM request/response, redirect and decode-side signals.
// Revision  : 1.0 - initial release
// ============================================================================
interface ins_prefetch_if;
  import fetch_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_out;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_plus_4_out;

  // master: the prefetch unit; slave: IMEM plus decode/redirect environment
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst_out, pc_out, pc_plus_4_out,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst_out, pc_out, pc_plus_4_out,
    output inst_ready
  );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Power-of-two FIFO with synchronous clear and zero-latency head.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     clear,
  input  wire logic                     push,
  input  wire logic [WIDTH-1:0]         push_data,
  input  wire logic                     pop,
  output logic      [WIDTH-1:0]         head,
  output logic      [$clog2(DEPTH):0]   count
);

  localparam int c_aw = $clog2(DEPTH);
  localparam logic [c_aw:0] c_depth = (c_aw+1)'(DEPTH);
  localparam logic [c_aw:0] c_one   = (c_aw+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;

  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_full = (r_count == c_depth);
  assign w_pop  = pop && (r_count != '0);
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign w_push = push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_one;
        2'b01:   r_count <= r_count - c_one;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !clear) r_mem[r_wr_ptr] <= push_data;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && w_full && !w_pop && !clear));

endmodule
`default_nettype wire

// File: rtl/ins_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : ins_prefetch
// Purpose  : Credit-limited instruction prefetcher with redirect and drop logic.
// Revision : 1.0 - initial release
// ============================================================================
module ins_prefetch
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  ins_prefetch_if.master     bus
);

  localparam int c_cw = $clog2(FIFO_DEPTH) + 1;
  localparam logic [c_cw-1:0] c_one   = c_cw'(1);
  localparam logic [c_cw:0]   c_depth = (c_cw+1)'(FIFO_DEPTH);

  logic [XLEN-1:0] r_fpc;
  logic [XLEN-1:0] r_rpc;
  logic [c_cw-1:0] r_inflight;
  logic [c_cw-1:0] r_drop_cnt;

  logic [c_cw-1:0] w_fifo_count;
  logic [c_cw:0]   w_used;
  logic            w_req_valid;
  logic            w_accept;
  logic            w_inst_valid;
  logic            w_pop;
  logic            w_keep;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head_entry;

  // Credits cover both buffered words and outstanding requests, so every
  // response always has a slot waiting for it.
  assign w_used       = {1'b0, r_inflight} + {1'b0, w_fifo_count};
  assign w_req_valid  = rst && (w_used < c_depth) && !bus.redirect_valid;
  assign w_accept     = w_req_valid && bus.imem_req_ready;
  assign w_inst_valid = (w_fifo_count != '0);
  assign w_pop        = w_inst_valid && bus.inst_ready && !bus.redirect_valid;
  assign w_keep       = bus.imem_rsp_valid && !bus.redirect_valid && (r_drop_cnt == '0);

  assign w_push_entry.instr = bus.imem_rsp_data;
  assign w_push_entry.pc    = r_rpc;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (bus.redirect_valid),
    .push      (w_keep),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .head      (w_head_entry),
    .count     (w_fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fpc      <= RESET_PC;
      r_rpc      <= RESET_PC;
      r_inflight <= '0;
      r_drop_cnt <= '0;
    end else if (bus.redirect_valid) begin
      // Everything still outstanding belongs to the old stream.
      r_fpc      <= bus.redirect_pc;
      r_rpc      <= bus.redirect_pc;
      r_drop_cnt <= r_inflight - c_cw'(bus.imem_rsp_valid);
      r_inflight <= r_inflight - c_cw'(bus.imem_rsp_valid);
    end else begin
      if (w_accept) r_fpc <= next_pc(r_fpc);
      unique case ({w_accept, bus.imem_rsp_valid})
        2'b10:   r_inflight <= r_inflight + c_one;
        2'b01:   r_inflight <= r_inflight - c_one;
        default: r_inflight <= r_inflight;
      endcase
      if (bus.imem_rsp_valid) begin
        if (r_drop_cnt != '0) r_drop_cnt <= r_drop_cnt - c_one;
        else                  r_rpc      <= next_pc(r_rpc);
      end
    end
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_fpc;
  assign bus.inst_valid     = w_inst_valid;
  assign bus.inst_out       = w_head_entry.instr;
  assign bus.pc_out         = w_head_entry.pc;
  assign bus.pc_plus_4_out  = next_pc(w_head_entry.pc);

endmodule
`default_nettype wire

// File: tb/tb_ins_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ins_prefetch
// Purpose  : Self-checking bench: queue-based reference model plus IMEM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ins_prefetch;

  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
  localparam int          DEPTH    = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ins_prefetch_if bus();

  ins_prefetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

  ent_t        mq[$];
  logic [31:0] pend[$];
  int          m_infl, m_drop;
  logic [31:0] m_fpc, m_rpc;

  logic [31:0] acc_log[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_p4[$];
  logic [31:0] pop_data[$];

  int n_chk  = 0;
  int n_fail = 0;
  int p_ready, p_rsp, p_iready;
  logic        last_rv;
  logic [31:0] last_addr;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hA5A5_5A5A;
  endfunction

  function automatic void reset_model();
    mq.delete();
    pend.delete();
    m_infl = 0;
    m_drop = 0;
    m_fpc  = RESET_PC;
    m_rpc  = RESET_PC;
  endfunction

  function automatic bit model_req_valid();
    return rst && (m_infl + mq.size() < DEPTH) && !bus.redirect_valid;
  endfunction

  function automatic void check_outputs();
    bit exp_rv;
    exp_rv = model_req_valid();
    chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", bus.imem_req_addr, m_fpc);
    chk("inst_valid", 32'(bus.inst_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("inst_out", bus.inst_out, mq[0].instr);
      chk("pc_out", bus.pc_out, mq[0].pc);
      chk("pc_plus_4", bus.pc_plus_4_out, mq[0].pc + 32'd4);
    end
  endfunction

  // Next state from the rules: credits, in-order responses, drop count, redirect flush.
  function automatic void model_step();
    bit   acc, rsp;
    ent_t e;
    if (!rst) begin
      reset_model();
      return;
    end
    acc = model_req_valid() && bus.imem_req_ready;
    rsp = bus.imem_rsp_valid;
    if (rsp && pend.size() != 0) void'(pend.pop_front());
    if (acc) pend.push_back(m_fpc);
    if (bus.redirect_valid) begin
      mq.delete();
      m_fpc  = bus.redirect_pc;
      m_rpc  = bus.redirect_pc;
      m_drop = m_infl - int'(rsp);
      m_infl = m_infl - int'(rsp);
    end else begin
      if (acc) m_fpc = m_fpc + 32'd4;
      m_infl = m_infl + int'(acc) - int'(rsp);
      if (mq.size() != 0 && bus.inst_ready) void'(mq.pop_front());
      if (rsp) begin
        if (m_drop > 0) m_drop--;
        else begin
          e.instr = bus.imem_rsp_data;
          e.pc    = m_rpc;
          mq.push_back(e);
          m_rpc = m_rpc + 32'd4;
        end
      end
    end
    if (mq.size() > DEPTH) chk("model_overflow", 32'(mq.size()), 32'(DEPTH));
  endfunction

  task automatic do_cycle(input bit redir, input logic [31:0] new_pc);
    @(negedge clk);
    bus.redirect_valid = redir;
    bus.redirect_pc    = new_pc;
    bus.imem_req_ready = ($urandom_range(99) < p_ready);
    bus.inst_ready     = ($urandom_range(99) < p_iready);
    if (rst && pend.size() != 0 && $urandom_range(99) < p_rsp) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = imem_word(pend[0]);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom();
    end
    #1;
    check_outputs();
    last_rv   = bus.imem_req_valid;
    last_addr = bus.imem_req_addr;
    if (bus.imem_req_valid && bus.imem_req_ready) acc_log.push_back(bus.imem_req_addr);
    if (bus.inst_valid && bus.inst_ready && !redir) begin
      pop_pc.push_back(bus.pc_out);
      pop_p4.push_back(bus.pc_plus_4_out);
      pop_data.push_back(bus.inst_out);
    end
    model_step();
  endtask

  task automatic drain();
    int k;
    k = 0;
    p_ready = 0;
    p_rsp   = 100;
    while (pend.size() != 0 && k < 20) begin
      do_cycle(1'b0, 32'h0);
      k++;
    end
    chk("drain_timeout", 32'(pend.size()), 32'd0);
  endtask

  task automatic load_three(input logic [31:0] base);
    drain();
    p_ready = 100; p_rsp = 0; p_iready = 100;
    do_cycle(1'b1, base);
    repeat (3) do_cycle(1'b0, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_idx, p_idx, n200;
    logic [31:0] rpc;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.inst_ready     = 1'b0;
    reset_model();
    p_ready = 100; p_rsp = 100; p_iready = 100;

    // Reset held, then wrap-around fetch from RESET_PC
    repeat (3) do_cycle(1'b0, 32'h0);
    chk("rst_req_valid", 32'(last_rv), 32'd0);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    @(posedge clk); #2 rst = 1'b1;
    repeat (8) do_cycle(1'b0, 32'h0);
    chk("wrap_addr0", acc_log[0], 32'hFFFF_FFF8);
    chk("wrap_addr1", acc_log[1], 32'hFFFF_FFFC);
    chk("wrap_addr2", acc_log[2], 32'h0000_0000);
    chk("wrap_pc0", pop_pc[0], 32'hFFFF_FFF8);
    chk("wrap_pc1", pop_pc[1], 32'hFFFF_FFFC);
    chk("wrap_p4_1", pop_p4[1], 32'h0000_0000);
    chk("wrap_p4_2", pop_p4[2], 32'h0000_0004);

    // Sequential stream from 0x0
    a_idx = acc_log.size(); p_idx = pop_pc.size();
    do_cycle(1'b1, 32'h0);
    repeat (8) do_cycle(1'b0, 32'h0);
    chk("seq_addr0", acc_log[a_idx],   32'h0);
    chk("seq_addr1", acc_log[a_idx+1], 32'h4);
    chk("seq_addr2", acc_log[a_idx+2], 32'h8);
    chk("seq_pc0", pop_pc[p_idx],   32'h0);
    chk("seq_pc1", pop_pc[p_idx+1], 32'h4);
    chk("seq_p4_0", pop_p4[p_idx],   32'h4);
    chk("seq_p4_1", pop_p4[p_idx+1], 32'h8);
    chk("seq_data0", pop_data[p_idx], imem_word(32'h0));

    // Back-pressure: credits stop at FIFO_DEPTH
    p_iready = 0;
    do_cycle(1'b1, 32'h40);
    a_idx = acc_log.size();
    repeat (10) do_cycle(1'b0, 32'h0);
    chk("bp_accepts", 32'(acc_log.size() - a_idx), 32'd4);
    chk("bp_req_off", 32'(last_rv), 32'd0);
    p_iready = 100;
    do_cycle(1'b0, 32'h0);
    chk("bp_pop_cycle_req", 32'(last_rv), 32'd0);
    chk("bp_pop_pc", pop_pc[pop_pc.size()-1], 32'h40);
    p_iready = 0;
    do_cycle(1'b0, 32'h0);
    chk("bp_5th_req", 32'(last_rv), 32'd1);
    chk("bp_5th_addr", last_addr, 32'h50);

    // Redirect with 3 in flight and a simultaneous response
    load_three(32'h80);
    p_idx = pop_pc.size();
    p_rsp = 100; p_ready = 0;
    do_cycle(1'b1, 32'h100);
    @(posedge clk); #1;
    chk("drop_cnt", 32'(dut.r_drop_cnt), 32'd2);
    p_ready = 100;
    repeat (12) do_cycle(1'b0, 32'h0);
    chk("rd1_have_pop", 32'(pop_pc.size() > p_idx), 32'd1);
    chk("rd1_pc", pop_pc[p_idx], 32'h100);
    chk("rd1_data", pop_data[p_idx], imem_word(32'h100));

    // Two redirects two cycles apart while dropping
    load_three(32'h180);
    p_idx = pop_pc.size();
    p_rsp = 100; p_ready = 0;
    do_cycle(1'b1, 32'h200);
    p_ready = 100;
    do_cycle(1'b0, 32'h0);
    do_cycle(1'b0, 32'h0);
    do_cycle(1'b1, 32'h300);
    repeat (12) do_cycle(1'b0, 32'h0);
    n200 = 0;
    for (int i = p_idx; i < pop_pc.size(); i++)
      if (pop_pc[i] >= 32'h200 && pop_pc[i] < 32'h300) n200++;
    chk("rd2_stale_pops", 32'(n200), 32'd0);
    chk("rd2_pc", pop_pc[p_idx], 32'h300);
    chk("rd2_data", pop_data[p_idx], imem_word(32'h300));

    // Randomised traffic
    for (int blk = 0; blk < 6; blk++) begin
      p_ready  = $urandom_range(100, 20);
      p_rsp    = $urandom_range(100, 20);
      p_iready = $urandom_range(100, 10);
      for (int c = 0; c < 500; c++) begin
        rpc = $urandom() & 32'hFFFF_FFFC;
        do_cycle($urandom_range(99) < 4, rpc);
      end
    end

    // Asynchronous reset with work outstanding
    p_ready = 100; p_rsp = 50; p_iready = 0;
    do_cycle(1'b1, 32'h400);
    repeat (4) do_cycle(1'b0, 32'h0);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.inst_ready     = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("async_req_valid", 32'(bus.imem_req_valid), 32'd0);
    reset_model();
    repeat (2) do_cycle(1'b0, 32'h0);
    @(posedge clk); #2 rst = 1'b1;
    p_ready = 100;
    do_cycle(1'b0, 32'h0);
    chk("post_rst_req", 32'(last_rv), 32'd1);
    chk("post_rst_addr", last_addr, RESET_PC);
    repeat (6) do_cycle(1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
